// File: rtl/exc_redirect_ctrl.sv
// exc_redirect_ctrl: exception / interrupt / ertn scheduler at the WB commit point.
// Picks one event per visit to IDLE, pulses the CSR commit, flushes the pipe and
// hands a redirect target to IF. Optional macro EXC_STATS_EN adds saturating
// per-cause event counters (stat_exc, stat_int, stat_ertn).
//
// state       | meaning
// ST_IDLE     | waiting for a WB event; ws_*/int_* inputs sampled here only
// ST_COMMIT   | one-cycle CSR commit pulse, flush asserted
// ST_REDIRECT | flush + redirect_valid held until IF accepts
module exc_redirect_ctrl #(
  parameter logic [5:0] ECODE_INT = 6'h00
`ifdef EXC_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic        ws_ex,
  input  logic [5:0]  ws_ecode,
  input  logic [8:0]  ws_esubcode,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_vaddr,
  input  logic        ws_ertn,
  input  logic [12:0] int_pending,
  input  logic        int_global_en,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        redirect_ready,
  output logic        exc_commit,
  output logic        ertn_commit,
  output logic [5:0]  exc_ecode,
  output logic [8:0]  exc_esubcode,
  output logic [31:0] exc_pc,
  output logic [31:0] exc_vaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
`ifdef EXC_STATS_EN
  output logic [CNT_W-1:0] stat_exc,
  output logic [CNT_W-1:0] stat_int,
  output logic [CNT_W-1:0] stat_ertn,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        is_ertn_q, is_ertn_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esub_q, esub_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [31:0] rpc_q, rpc_d;
  logic        exc_commit_q, exc_commit_d;
  logic        ertn_commit_q, ertn_commit_d;
  logic        flush_q, flush_d;
  logic        rvalid_q, rvalid_d;
  logic        busy_q, busy_d;

  logic        int_take;
  logic        take_int, take_exc, take_ertn;

  // Next-state, event arbitration and field capture; output flops are derived
  // from the next state so every output comes straight from a register.
  always_comb begin
    state_d   = state_q;
    is_ertn_d = is_ertn_q;
    ecode_d   = ecode_q;
    esub_d    = esub_q;
    pc_d      = pc_q;
    vaddr_d   = vaddr_q;
    rpc_d     = rpc_q;
    take_int  = 1'b0;
    take_exc  = 1'b0;
    take_ertn = 1'b0;
    int_take  = ws_valid & int_global_en & (|int_pending);

    unique case (state_q)
      ST_IDLE: begin
        if (ws_valid) begin
          if (int_take) begin
            take_int = 1'b1;
          end else if (ws_ex) begin
            take_exc = 1'b1;
          end else if (ws_ertn) begin
            take_ertn = 1'b1;
          end
        end
        if (take_int | take_exc | take_ertn) begin
          state_d   = ST_COMMIT;
          is_ertn_d = take_ertn;
          pc_d      = ws_pc;
          if (take_int) begin
            ecode_d = ECODE_INT;
            esub_d  = 9'd0;
            vaddr_d = 32'd0;
          end else begin
            ecode_d = ws_ecode;
            esub_d  = ws_esubcode;
            vaddr_d = ws_vaddr;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_REDIRECT;
        rpc_d   = is_ertn_q ? csr_era : csr_eentry;
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    exc_commit_d  = (state_d == ST_COMMIT) & ~is_ertn_d;
    ertn_commit_d = (state_d == ST_COMMIT) & is_ertn_d;
    flush_d       = (state_d != ST_IDLE);
    rvalid_d      = (state_d == ST_REDIRECT);
    busy_d        = (state_d != ST_IDLE);
  end

  // State, latched fields and registered outputs; reset aborts any sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      is_ertn_q     <= 1'b0;
      ecode_q       <= '0;
      esub_q        <= '0;
      pc_q          <= '0;
      vaddr_q       <= '0;
      rpc_q         <= '0;
      exc_commit_q  <= 1'b0;
      ertn_commit_q <= 1'b0;
      flush_q       <= 1'b0;
      rvalid_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_ertn_q     <= is_ertn_d;
      ecode_q       <= ecode_d;
      esub_q        <= esub_d;
      pc_q          <= pc_d;
      vaddr_q       <= vaddr_d;
      rpc_q         <= rpc_d;
      exc_commit_q  <= exc_commit_d;
      ertn_commit_q <= ertn_commit_d;
      flush_q       <= flush_d;
      rvalid_q      <= rvalid_d;
      busy_q        <= busy_d;
    end
  end

  assign exc_commit     = exc_commit_q;
  assign ertn_commit    = ertn_commit_q;
  assign exc_ecode      = ecode_q;
  assign exc_esubcode   = esub_q;
  assign exc_pc         = pc_q;
  assign exc_vaddr      = vaddr_q;
  assign flush          = flush_q;
  assign redirect_valid = rvalid_q;
  assign redirect_pc    = rpc_q;
  assign busy           = busy_q;

`ifdef EXC_STATS_EN
  logic [CNT_W-1:0] stat_exc_q, stat_exc_d;
  logic [CNT_W-1:0] stat_int_q, stat_int_d;
  logic [CNT_W-1:0] stat_ertn_q, stat_ertn_d;

  // Per-cause counters bump on entry to COMMIT and stick at all-ones.
  always_comb begin
    stat_exc_d  = stat_exc_q;
    stat_int_d  = stat_int_q;
    stat_ertn_d = stat_ertn_q;
    if (take_exc && (stat_exc_q != '1)) begin
      stat_exc_d = stat_exc_q + CNT_W'(1);
    end
    if (take_int && (stat_int_q != '1)) begin
      stat_int_d = stat_int_q + CNT_W'(1);
    end
    if (take_ertn && (stat_ertn_q != '1)) begin
      stat_ertn_d = stat_ertn_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_exc_q  <= '0;
      stat_int_q  <= '0;
      stat_ertn_q <= '0;
    end else begin
      stat_exc_q  <= stat_exc_d;
      stat_int_q  <= stat_int_d;
      stat_ertn_q <= stat_ertn_d;
    end
  end

  assign stat_exc  = stat_exc_q;
  assign stat_int  = stat_int_q;
  assign stat_ertn = stat_ertn_q;
`endif

endmodule
